mult_rr_sched: RTL and testbench
================================

Name: mult_rr_sched

Overview:
Shares one sequential shift-add multiplier between NREQ requesters.
- Arbitrates round-robin and latches the winner's operands.
- Sequences exactly W add/shift iterations, then returns a tagged product over a valid/ready response channel.
- Sits between client blocks and the multiply datapath, so clients never drive load, clock-phase or count logic themselves.

Parameters:
NREQ, 4, number of requesters (2..8); IDW = $clog2(NREQ) is a derived localparam
W, 8, operand width in bits; product width is 2*W

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
req_valid  input  NREQ  per-requester request valid
req_a  input  NREQ*W  packed multiplicands; requester i uses bits [i*W +: W]
req_b  input  NREQ*W  packed multipliers, same packing as req_a
req_ready  output  NREQ  one-hot accept strobe; combinational from state and req_valid
resp_valid  output  1  product available
resp_ready  input  1  consumer accepts product
resp_data  output  2*W  product a*b, unsigned
resp_id  output  IDW  index of the requester that owns resp_data
busy  output  1  high in RUN and DONE

Behaviour:
- Reset values: state IDLE, rr_ptr 0, acc 0, resp_valid 0, resp_data 0, resp_id 0, busy 0. req_ready is 0 while rst is high.
- States: IDLE, RUN, DONE. Encoding comes from the package.
- IDLE:
  - If any req_valid bit is set, grant the first asserted index at or after rr_ptr, searching cyclically.
  - req_ready[g] = 1 in that same cycle; all other req_ready bits are 0.
  - On the clock edge: regA <= {W zeros, req_a[g]}, regB <= req_b[g], acc <= 0, cnt <= W, id <= g, rr_ptr <= (g+1) mod NREQ, state -> RUN.
  - If no req_valid bit is set, stay in IDLE; all req_ready bits are 0.
- RUN, each cycle:
  - If regB[0] = 1, acc <= acc + regA (2W-bit add, cannot overflow).
  - regA <= regA << 1; regB <= regB >> 1; cnt <= cnt - 1.
  - When cnt == 1 on the edge, state -> DONE, resp_valid <= 1.
  - Always exactly W iterations; no early exit on zero operands, so latency is deterministic.
- DONE:
  - resp_data = acc and resp_id = id, both held stable while resp_valid = 1.
  - When resp_valid & resp_ready: resp_valid <= 0, state -> IDLE.
  - The next grant can start in the IDLE cycle that follows; no bypass from DONE straight into a new grant.
- Latency: a request accepted on edge t gives resp_valid = 1 after edge t+W. Back-to-back with resp_ready tied high, one product completes every W+2 cycles.
- Requester protocol:
  - req_valid must stay high with stable operands until req_ready.
  - Operands are sampled only on the accept edge.
  - A requester that drops req_valid before it is granted is simply not served.
- No new acceptance while busy; all req_ready bits are 0 in RUN and DONE.
- Fairness: a requester with valid held continuously is served within NREQ grants.
- Simultaneous events: resp_ready arriving in the same cycle that DONE is entered has no effect, because resp_valid is not yet high. Requests asserted in the DONE handshake cycle are arbitrated in the next IDLE cycle.
- Reset mid-operation, in RUN or DONE: the product is discarded, no response is issued, and all state returns to reset values, including rr_ptr = 0.
- W-bit operand edges: 0 * x = 0; (2^W - 1)^2 = 2^(2W) - 2^(W+1) + 1 fits in 2W bits.

Decomposition:
- Shared package mult_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - default width constant MULT_W = 8
  - function for the cyclic priority search
- One sub-module, mult_rr_arbiter:
  - combinational request vector plus rr_ptr in, one-hot grant plus encoded index out
  - rr_ptr register stays in mult_rr_sched
- The datapath (regA, regB, acc, cnt) stays inline in mult_rr_sched.

Test Plan:
- Single request: req 0 with a=13, b=11, resp_ready=1 -> req_ready[0] for 1 cycle; resp_valid exactly 8 cycles after the accept edge; resp_data=143, resp_id=0.
- Extremes: a=255, b=255 -> 65025; a=0, b=200 -> 0, still after 8 cycles; a=1, b=128 -> 128.
- Contention from reset: all 4 req_valid high, requester i uses a=i+1, b=10 -> grants in order 0,1,2,3; results 10,20,30,40 with matching resp_id; one product every 10 cycles.
- Fairness: req 1 and req 3 held continuously -> grants alternate 1,3,1,3 and never starve.
- Backpressure: resp_ready low for 5 cycles after resp_valid -> resp_data and resp_id stable, busy=1, all req_ready=0; release -> resp_valid falls, next grant 1 cycle later.
- Reset mid-RUN: assert rst at iteration 4 of a 7*9 multiply -> no resp_valid, busy=0 next cycle, rr_ptr=0; next request with a=7, b=9 yields 63.

Source files
------------

// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the round-robin multiplier scheduler:
//   - state_t   : scheduler FSM states (IDLE, RUN, DONE)
//   - MULT_W    : default operand width
//   - MAX_REQ   : widest request vector the search function handles
//   - rr_search : cyclic priority search starting at a pointer
// -----------------------------------------------------------------------------
package mult_pkg;

    localparam int MULT_W  = 8;
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns 1 when any of the low n bits of req is set; idx receives the
    // first set index at or after ptr, wrapping past n-1 back to 0.
    // Candidates are scanned from farthest to nearest so the nearest hit is
    // the one left in idx.
    function automatic logic rr_search(input  logic [MAX_REQ-1:0] req,
                                       input  int                 n,
                                       input  int                 ptr,
                                       output int                 idx);
        logic found;
        int   cand;
        found = 1'b0;
        idx   = 0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                cand = ptr + k;
                if (cand >= n) begin
                    cand = cand - n;
                end
                if (req[3'(cand)]) begin
                    found = 1'b1;
                    idx   = cand;
                end
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/mult_rr_sched_if.sv
// -----------------------------------------------------------------------------
// mult_rr_sched_if
// Request and response channels between client blocks and the shared
// multiplier scheduler.
//   req_valid  : per-requester request valid
//   req_a/b    : packed operands, requester i at [i*W +: W]
//   req_ready  : one-hot accept strobe from the scheduler
//   resp_valid : product available
//   resp_ready : consumer accepts product
//   resp_data  : unsigned product, 2*W bits
//   resp_id    : index of the requester owning resp_data
// master = client side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface mult_rr_sched_if
    import mult_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = MULT_W
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [2*W-1:0]    resp_data;
    logic [IDW-1:0]    resp_id;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id
    );

endinterface

// File: rtl/mult_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mult_rr_arbiter
// Purely combinational round-robin pick.
//   req       : request vector
//   rr_ptr    : index with highest priority this cycle
//   grant     : one-hot winner (all zero when nothing requests)
//   grant_idx : encoded winner index
//   grant_any : at least one request present
// The pointer register lives in the parent.
// -----------------------------------------------------------------------------
module mult_rr_arbiter
    import mult_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]          req,
    input  logic [$clog2(NREQ)-1:0]  rr_ptr,
    output logic [NREQ-1:0]          grant,
    output logic [$clog2(NREQ)-1:0]  grant_idx,
    output logic                     grant_any
);

    localparam int IDW = $clog2(NREQ);

    // NOTE: every output gets a default before any conditional assignment,
    // so no path through the block leaves a value held (no latch).
    always_comb begin
        int pick;
        pick      = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = rr_search(MAX_REQ'(req), NREQ, int'(rr_ptr), pick);
        for (int i = 0; i < NREQ; i++) begin
            if (grant_any && (pick == i)) begin
                grant[i]  = 1'b1;
                grant_idx = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/mult_rr_sched.sv
// -----------------------------------------------------------------------------
// mult_rr_sched
// Shares one sequential shift-add multiplier between NREQ requesters.
// A round-robin pick in IDLE latches the winner's operands, RUN performs
// exactly W add/shift iterations, and DONE holds the tagged product on the
// response channel until the consumer takes it.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mult_rr_sched_if slave (request and response channels)
//   busy : high in RUN and DONE
// -----------------------------------------------------------------------------
module mult_rr_sched
    import mult_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = MULT_W
) (
    input  logic           clk,
    input  logic           rst,
    mult_rr_sched_if.slave bus,
    output logic           busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(W + 1);

    state_t          state;
    state_t          state_nx;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  id;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;
    logic [W-1:0]    a_sel;
    logic [W-1:0]    b_sel;
    logic [2*W-1:0]  reg_a;
    logic [W-1:0]    reg_b;
    logic [2*W-1:0]  acc;
    logic [CW-1:0]   cnt;

    mult_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (bus.req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign a_sel = bus.req_a[int'(grant_idx) * W +: W];
    assign b_sel = bus.req_b[int'(grant_idx) * W +: W];

    // Response channel is a direct view of the held datapath state.
    assign bus.resp_valid = (state == DONE);
    assign bus.resp_data  = acc;
    assign bus.resp_id    = id;
    assign busy           = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Grants are offered only in IDLE and never during reset. DONE always
    // returns to IDLE first, so a new grant cannot bypass that cycle.
    always_comb begin
        state_nx      = state;
        bus.req_ready = '0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    bus.req_ready = grant;
                end
                if (grant_any) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (bus.resp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: the datapath registers are few and narrow, so all of them are
    // reset; this keeps resp_data/resp_id at zero after reset and discards
    // any partial product when reset lands mid-operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            id     <= '0;
            reg_a  <= '0;
            reg_b  <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, e.g. the add uses the old reg_a
            // while reg_a shifts in the same cycle.
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        reg_a <= {{W{1'b0}}, a_sel};
                        reg_b <= b_sel;
                        acc   <= '0;
                        cnt   <= CW'(W);
                        id    <= grant_idx;
                        if (grant_idx == IDW'(NREQ - 1)) begin
                            rr_ptr <= '0;
                        end else begin
                            rr_ptr <= grant_idx + IDW'(1);
                        end
                    end
                end
                RUN: begin
                    // Fixed W iterations regardless of operand values.
                    if (reg_b[0]) begin
                        acc <= acc + reg_a;
                    end
                    reg_a <= reg_a << 1;
                    reg_b <= reg_b >> 1;
                    cnt   <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_mult_rr_sched
// Directed bench for mult_rr_sched. Stimulus pushes the expected product and
// owner into a scoreboard when a grant is seen; a monitor pops and compares on
// every response handshake. Timing, grant order and stall behaviour are
// compared inline by the stimulus process.
// -----------------------------------------------------------------------------
module tb_mult_rr_sched;
    import mult_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    typedef struct {
        logic [2*W-1:0] data;
        logic [IDW-1:0] id;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    exp_t sb[$];

    mult_rr_sched_if #(.NREQ(NREQ), .W(W)) bus ();

    mult_rr_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compares every accepted response.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.resp_valid && bus.resp_ready) begin
            check("resp_expected_empty", 64'(sb.size() == 0), 64'd0);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("resp_data", 64'(bus.resp_data), 64'(e.data));
                check("resp_id", 64'(bus.resp_id), 64'(e.id));
            end
        end
    end

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_valid[i]     = 1'b1;
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
    endtask

    task automatic push_exp(input int i, input logic [2*W-1:0] d);
        exp_t e;
        e.data = d;
        e.id   = IDW'(i);
        sb.push_back(e);
    endtask

    task automatic wait_grant(output logic [NREQ-1:0] g);
        g = '0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                g = bus.req_ready;
                break;
            end
        end
    endtask

    // Waits for requester i to be granted, records the expected result and
    // returns the cycle number of the accept edge.
    task automatic grant_and_accept(input string name, input int i,
                                    input logic [2*W-1:0] d, output int acc_cyc);
        logic [NREQ-1:0] g;
        wait_grant(g);
        check(name, 64'(g), 64'(4'b0001 << i));
        push_exp(i, d);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
    endtask

    task automatic wait_resp(output int c);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.resp_valid) break;
        end
        c = cyc;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) break;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One isolated request with resp_ready high.
    task automatic single(input string name, input int i, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2*W-1:0] d);
        int t_acc;
        int t_rsp;
        set_req(i, a, b);
        grant_and_accept({name, "_grant"}, i, d, t_acc);
        @(negedge clk);
        check({name, "_ready_one_cycle"}, 64'(bus.req_ready), 64'd0);
        bus.req_valid[i] = 1'b0;
        wait_resp(t_rsp);
        check({name, "_latency"}, 64'(t_rsp - t_acc), 64'(W));
        check({name, "_busy_done"}, 64'(busy), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int              t_acc;
        int              t_prev;
        int              t_rsp;
        logic [NREQ-1:0] g;

        rst            = 1'b1;
        bus.req_valid  = '1;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;
        t_prev         = 0;

        // Reset: no accepts while rst is high even with all requests valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_data", 64'(bus.resp_data), 64'd0);
        check("rst_resp_id", 64'(bus.resp_id), 64'd0);
        @(posedge clk);
        #1;

        // Single requests and operand extremes.
        single("single_13x11", 0, 8'd13, 8'd11, 16'd143);
        single("max_255x255", 0, 8'd255, 8'd255, 16'd65025);
        single("zero_0x200", 2, 8'd0, 8'd200, 16'd0);
        single("one_1x128", 3, 8'd1, 8'd128, 16'd128);

        // Contention from reset: all four valid, served 0,1,2,3, ten cycles apart.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 8'(i + 1), 8'd10);
        end
        for (int k = 0; k < NREQ; k++) begin
            grant_and_accept("contend_grant", k, 16'((k + 1) * 10), t_acc);
            if (k > 0) begin
                check("contend_spacing", 64'(t_acc - t_prev), 64'(W + 2));
            end
            t_prev           = t_acc;
            bus.req_valid[k] = 1'b0;
        end
        wait_idle();

        // Fairness: requesters 1 and 3 held continuously alternate.
        set_req(1, 8'd3, 8'd5);
        set_req(3, 8'd6, 8'd7);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) grant_and_accept("fair_grant", 1, 16'd15, t_acc);
            else            grant_and_accept("fair_grant", 3, 16'd42, t_acc);
        end
        bus.req_valid = '0;
        wait_idle();

        // Backpressure: response held five cycles with a competing request.
        bus.resp_ready = 1'b0;
        set_req(2, 8'd20, 8'd30);
        grant_and_accept("bp_grant", 2, 16'd600, t_acc);
        bus.req_valid[2] = 1'b0;
        wait_resp(t_rsp);
        check("bp_latency", 64'(t_rsp - t_acc), 64'(W));
        set_req(0, 8'd2, 8'd2);
        for (int j = 0; j < 5; j++) begin
            check("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
            check("bp_resp_data", 64'(bus.resp_data), 64'd600);
            check("bp_resp_id", 64'(bus.resp_id), 64'd2);
            check("bp_busy", 64'(busy), 64'd1);
            check("bp_req_ready", 64'(bus.req_ready), 64'd0);
            if (j < 4) @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_release_valid", 64'(bus.resp_valid), 64'd0);
        check("bp_next_grant", 64'(bus.req_ready), 64'b0001);
        push_exp(0, 16'd4);
        @(posedge clk);
        #1;
        bus.req_valid[0] = 1'b0;
        wait_idle();

        // Reset during RUN of 7*9: no response, pointer back to 0.
        set_req(1, 8'd7, 8'd9);
        wait_grant(g);
        check("abort_grant", 64'(g), 64'b0010);
        @(posedge clk);
        #1;
        bus.req_valid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        set_req(1, 8'd7, 8'd9);
        set_req(3, 8'd2, 8'd3);
        @(negedge clk);
        check("abort_rst_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("abort_resp_data", 64'(bus.resp_data), 64'd0);
        check("abort_ptr_grant", 64'(bus.req_ready), 64'b0010);
        push_exp(1, 16'd63);
        @(posedge clk);
        #1;
        bus.req_valid[1] = 1'b0;
        grant_and_accept("abort_next_grant", 3, 16'd6, t_acc);
        bus.req_valid[3] = 1'b0;
        wait_idle();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
